// File: rtl/fifo_enqueue_arbiter_pkg.sv
// Shared constants and types for the FIFO enqueue arbiter and its round-robin core.
package fifo_enqueue_arbiter_pkg;

    localparam int FIFO_ARB_MAX_REQUESTERS = 16;
    localparam int FIFO_ARB_MAX_FIFO_SIZE  = 1024;
    localparam int FIFO_ARB_CREDIT_W       = $clog2(FIFO_ARB_MAX_FIFO_SIZE) + 1;

    typedef logic [FIFO_ARB_CREDIT_W-1:0] fifo_arb_credit_t;

    typedef enum logic [1:0] {
        CREDIT_HOLD,
        CREDIT_TAKE,
        CREDIT_RETURN
    } credit_op_e;

endpackage

// File: rtl/fifo_enqueue_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the lane after the last winner.
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_oh = '0;
        winner   = last_grant;
        idx      = '0;
        found    = 1'b0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % NUM_REQUESTERS);
            if (!found && request[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                winner        = idx;
            end
        end
    end

    // Reset points at the top lane so lane 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_REQUESTERS - 1);
        end else if (update_lru && found) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/fifo_enqueue_arbiter.sv
// Credit-tracked round-robin arbiter feeding one sync FIFO write port.
// Optional macro FIFO_ARB_PRIORITY_EN makes lane 0 a strict high-priority lane.
module fifo_enqueue_arbiter
    import fifo_enqueue_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int WIDTH          = 64,
    parameter int FIFO_SIZE      = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush_en,
    input  logic [NUM_REQUESTERS-1:0]       request,
    input  logic [WIDTH-1:0]                request_data [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0]       grant_oh,
    output logic                            fifo_enqueue_en,
    output logic [WIDTH-1:0]                fifo_value,
    input  logic                            fifo_dequeue_en,
    output logic [$clog2(FIFO_SIZE):0]      credits
);

    localparam int CW = $clog2(FIFO_SIZE) + 1;

    function automatic fifo_arb_credit_t credit_next(input fifo_arb_credit_t cur,
                                                     input credit_op_e op);
        case (op)
            CREDIT_TAKE:   return cur - fifo_arb_credit_t'(1);
            CREDIT_RETURN: return cur + fifo_arb_credit_t'(1);
            default:       return cur;
        endcase
    endfunction

    logic [CW-1:0]             credits_q;
    logic                      can_grant;
    logic [NUM_REQUESTERS-1:0] rr_req;
    logic [NUM_REQUESTERS-1:0] rr_grant;
    logic [NUM_REQUESTERS-1:0] grant_comb;
    logic                      update_lru;
    logic                      grant_any;
    logic [WIDTH-1:0]          win_data;
    credit_op_e                credit_op;
    logic                      vld_p1;
    logic [WIDTH-1:0]          data_p1;

    assign can_grant = (credits_q != '0) && !flush_en;

`ifdef FIFO_ARB_PRIORITY_EN
    // Lane 0 bypasses the pointer; its wins leave the rotation untouched.
    logic lane0_win;
    assign lane0_win  = can_grant && request[0];
    assign rr_req     = can_grant ? {request[NUM_REQUESTERS-1:1], 1'b0} : '0;
    assign grant_comb = lane0_win ? NUM_REQUESTERS'(1) : rr_grant;
    assign update_lru = !lane0_win;
`else
    assign rr_req     = can_grant ? request : '0;
    assign grant_comb = rr_grant;
    assign update_lru = 1'b1;
`endif

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .request   (rr_req),
        .update_lru(update_lru),
        .grant_oh  (rr_grant)
    );

    assign grant_oh  = reset_n ? grant_comb : '0;
    assign grant_any = |grant_oh;
    assign credits   = credits_q;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_oh[i]) win_data = win_data | request_data[i];
        end
    end

    // A same-cycle grant and dequeue cancel out.
    always_comb begin
        credit_op = CREDIT_HOLD;
        if (grant_any && !fifo_dequeue_en)      credit_op = CREDIT_TAKE;
        else if (!grant_any && fifo_dequeue_en) credit_op = CREDIT_RETURN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits_q <= CW'(FIFO_SIZE);
        end else if (flush_en) begin
            credits_q <= CW'(FIFO_SIZE);
        end else begin
            credits_q <= CW'(credit_next(fifo_arb_credit_t'(credits_q), credit_op));
        end
    end

    // ---- stage p1: registered enqueue toward the FIFO ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= grant_any && !flush_en;
            if (grant_any) data_p1 <= win_data;
        end
    end

    assign fifo_enqueue_en = vld_p1;
    assign fifo_value      = data_p1;

`ifndef SYNTHESIS
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
        credits_q <= CW'(FIFO_SIZE));
    a_no_dequeue_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        (fifo_dequeue_en && !flush_en) |-> (credits_q != CW'(FIFO_SIZE)));
`endif

endmodule

// File: tb/tb_fifo_enqueue_arbiter.sv
// Directed bench for fifo_enqueue_arbiter with N=4, WIDTH=64, FIFO_SIZE=4.
module tb_fifo_enqueue_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int FS = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush_en;
    logic [N-1:0]  request;
    logic [W-1:0]  request_data [N];
    logic [N-1:0]  grant_oh;
    logic          fifo_enqueue_en;
    logic [W-1:0]  fifo_value;
    logic          fifo_dequeue_en;
    logic [CW-1:0] credits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_enqueue_arbiter #(
        .NUM_REQUESTERS(N),
        .WIDTH         (W),
        .FIFO_SIZE     (FS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_en       (flush_en),
        .request        (request),
        .request_data   (request_data),
        .grant_oh       (grant_oh),
        .fifo_enqueue_en(fifo_enqueue_en),
        .fifo_value     (fifo_value),
        .fifo_dequeue_en(fifo_dequeue_en),
        .credits        (credits)
    );

    function automatic logic [W-1:0] lane_data(input int lane, input int k);
        return {32'hC0DE_0000 | 32'(lane), 32'(k)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; flush_en = 1'b0; fifo_dequeue_en = 1'b0; request = 4'b1111;
        for (int i = 0; i < N; i++) request_data[i] = lane_data(i, 0);
        tick; tick; settle;
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=%b", grant_oh, 4'b0000); end
        checks++; if (credits !== 3'd4) begin errors++; $display("FAIL rst_credits got=%0d exp=%0d", credits, 4); end
        checks++; if (fifo_enqueue_en !== 1'b0) begin errors++; $display("FAIL rst_enq got=%b exp=%b", fifo_enqueue_en, 1'b0); end
        checks++; if (fifo_value !== 64'd0) begin errors++; $display("FAIL rst_value got=%h exp=%h", fifo_value, 64'd0); end
        request = 4'b0000;
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin;
        tick; request = 4'b1111; settle;
        checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL rr_grant0 got=%b exp=%b", grant_oh, 4'b0001); end
        checks++; if (fifo_enqueue_en !== 1'b0) begin errors++; $display("FAIL rr_enq0 got=%b exp=%b", fifo_enqueue_en, 1'b0); end
        for (int c = 1; c < 4; c++) begin
            tick; settle;
            checks++; if (grant_oh !== 4'(1 << c)) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant_oh, 4'(1 << c)); end
            checks++; if (credits !== 3'(4 - c)) begin errors++; $display("FAIL rr_credits c=%0d got=%0d exp=%0d", c, credits, 4 - c); end
            checks++; if (fifo_enqueue_en !== 1'b1) begin errors++; $display("FAIL rr_enq c=%0d got=%b exp=%b", c, fifo_enqueue_en, 1'b1); end
            checks++; if (fifo_value !== lane_data(c - 1, 0)) begin errors++; $display("FAIL rr_value c=%0d got=%h exp=%h", c, fifo_value, lane_data(c - 1, 0)); end
        end
        tick; settle;
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL rr_nocredit_grant got=%b exp=%b", grant_oh, 4'b0000); end
        checks++; if (credits !== 3'd0) begin errors++; $display("FAIL rr_credits_zero got=%0d exp=%0d", credits, 0); end
        checks++; if (fifo_value !== lane_data(3, 0)) begin errors++; $display("FAIL rr_value3 got=%h exp=%h", fifo_value, lane_data(3, 0)); end
        tick; request = 4'b0000; settle;
        checks++; if (fifo_enqueue_en !== 1'b0) begin errors++; $display("FAIL rr_enq_idle got=%b exp=%b", fifo_enqueue_en, 1'b0); end
        checks++; if (fifo_value !== lane_data(3, 0)) begin errors++; $display("FAIL rr_value_hold got=%h exp=%h", fifo_value, lane_data(3, 0)); end
    endtask

    task automatic test_credit_zero_dequeue;
        tick; request = 4'b0100; fifo_dequeue_en = 1'b1; settle;
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL cz_grant got=%b exp=%b", grant_oh, 4'b0000); end
        tick; fifo_dequeue_en = 1'b0; settle;
        checks++; if (credits !== 3'd1) begin errors++; $display("FAIL cz_credits1 got=%0d exp=%0d", credits, 1); end
        checks++; if (grant_oh !== 4'b0100) begin errors++; $display("FAIL cz_grant2 got=%b exp=%b", grant_oh, 4'b0100); end
        tick; request = 4'b0000; settle;
        checks++; if (credits !== 3'd0) begin errors++; $display("FAIL cz_credits0 got=%0d exp=%0d", credits, 0); end
        checks++; if (fifo_value !== lane_data(2, 0)) begin errors++; $display("FAIL cz_value got=%h exp=%h", fifo_value, lane_data(2, 0)); end
    endtask

    task automatic test_grant_and_dequeue;
        tick; fifo_dequeue_en = 1'b1;
        tick;
        tick; request = 4'b0001; request_data[0] = lane_data(0, 7); settle;
        checks++; if (credits !== 3'd2) begin errors++; $display("FAIL gd_credits_before got=%0d exp=%0d", credits, 2); end
        checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL gd_grant got=%b exp=%b", grant_oh, 4'b0001); end
        tick; request = 4'b0000; fifo_dequeue_en = 1'b0; settle;
        checks++; if (credits !== 3'd2) begin errors++; $display("FAIL gd_credits_after got=%0d exp=%0d", credits, 2); end
        checks++; if (fifo_enqueue_en !== 1'b1) begin errors++; $display("FAIL gd_enq got=%b exp=%b", fifo_enqueue_en, 1'b1); end
        checks++; if (fifo_value !== lane_data(0, 7)) begin errors++; $display("FAIL gd_value got=%h exp=%h", fifo_value, lane_data(0, 7)); end
    endtask

    task automatic test_flush;
        tick; request = 4'b0010; settle;
        checks++; if (grant_oh !== 4'b0010) begin errors++; $display("FAIL fl_grant_pre got=%b exp=%b", grant_oh, 4'b0010); end
        tick; request = 4'b0100; flush_en = 1'b1; fifo_dequeue_en = 1'b1; settle;
        checks++; if (credits !== 3'd1) begin errors++; $display("FAIL fl_credits_pre got=%0d exp=%0d", credits, 1); end
        checks++; if (fifo_enqueue_en !== 1'b1) begin errors++; $display("FAIL fl_inflight got=%b exp=%b", fifo_enqueue_en, 1'b1); end
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL fl_grant_during got=%b exp=%b", grant_oh, 4'b0000); end
        tick; flush_en = 1'b0; fifo_dequeue_en = 1'b0; request = 4'b1111; settle;
        checks++; if (fifo_enqueue_en !== 1'b0) begin errors++; $display("FAIL fl_enq_after got=%b exp=%b", fifo_enqueue_en, 1'b0); end
        checks++; if (credits !== 3'd4) begin errors++; $display("FAIL fl_credits_after got=%0d exp=%0d", credits, 4); end
        checks++; if (grant_oh !== 4'b0100) begin errors++; $display("FAIL fl_ptr_kept got=%b exp=%b", grant_oh, 4'b0100); end
        tick; request = 4'b0000; settle;
        checks++; if (fifo_value !== lane_data(2, 0)) begin errors++; $display("FAIL fl_value got=%h exp=%h", fifo_value, lane_data(2, 0)); end
        checks++; if (credits !== 3'd3) begin errors++; $display("FAIL fl_credits_next got=%0d exp=%0d", credits, 3); end
    endtask

    task automatic test_reset_mid;
        tick; request = 4'b1010; settle;
        checks++; if (grant_oh !== 4'b1000) begin errors++; $display("FAIL rm_grant_pre got=%b exp=%b", grant_oh, 4'b1000); end
        reset_n = 1'b0; #1;
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL rm_grant_rst got=%b exp=%b", grant_oh, 4'b0000); end
        checks++; if (credits !== 3'd4) begin errors++; $display("FAIL rm_credits_rst got=%0d exp=%0d", credits, 4); end
        checks++; if (fifo_enqueue_en !== 1'b0) begin errors++; $display("FAIL rm_enq_rst got=%b exp=%b", fifo_enqueue_en, 1'b0); end
        tick; reset_n = 1'b1; settle;
        checks++; if (grant_oh !== 4'b0010) begin errors++; $display("FAIL rm_first_grant got=%b exp=%b", grant_oh, 4'b0010); end
        tick; request = 4'b0000; settle;
        checks++; if (fifo_value !== lane_data(1, 0)) begin errors++; $display("FAIL rm_value got=%h exp=%h", fifo_value, lane_data(1, 0)); end
        checks++; if (credits !== 3'd3) begin errors++; $display("FAIL rm_credits got=%0d exp=%0d", credits, 3); end
    endtask

    task automatic test_back_to_back;
        for (int k = 1; k <= 3; k++) begin
            tick; request = 4'b0100; request_data[2] = lane_data(2, k); fifo_dequeue_en = 1'b1; settle;
            checks++; if (grant_oh !== 4'b0100) begin errors++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, grant_oh, 4'b0100); end
            checks++; if (credits !== 3'd3) begin errors++; $display("FAIL b2b_credits k=%0d got=%0d exp=%0d", k, credits, 3); end
            if (k > 1) begin
                checks++; if (fifo_value !== lane_data(2, k - 1)) begin errors++; $display("FAIL b2b_value k=%0d got=%h exp=%h", k, fifo_value, lane_data(2, k - 1)); end
            end
        end
        tick; request = 4'b0000; fifo_dequeue_en = 1'b0; settle;
        checks++; if (fifo_value !== lane_data(2, 3)) begin errors++; $display("FAIL b2b_value_last got=%h exp=%h", fifo_value, lane_data(2, 3)); end
        checks++; if (fifo_enqueue_en !== 1'b1) begin errors++; $display("FAIL b2b_enq got=%b exp=%b", fifo_enqueue_en, 1'b1); end
    endtask

`ifdef FIFO_ARB_PRIORITY_EN
    task automatic test_priority;
        tick; reset_n = 1'b0; tick; reset_n = 1'b1;
        tick; request = 4'b1011;
        for (int c = 0; c < 4; c++) begin
            settle;
            checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL pr_lane0 c=%0d got=%b exp=%b", c, grant_oh, 4'b0001); end
            checks++; if (credits !== 3'(4 - c)) begin errors++; $display("FAIL pr_credits c=%0d got=%0d exp=%0d", c, credits, 4 - c); end
            tick;
        end
        settle;
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL pr_exhausted got=%b exp=%b", grant_oh, 4'b0000); end
        reset_n = 1'b0; tick; reset_n = 1'b1;
        tick; request = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            settle;
            checks++; if (grant_oh !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin errors++; $display("FAIL pr_alt c=%0d got=%b exp=%b", c, grant_oh, (c % 2 == 0) ? 4'b0010 : 4'b1000); end
            tick;
        end
        request = 4'b0000;
    endtask
`endif

    initial begin
        test_reset;
`ifdef FIFO_ARB_PRIORITY_EN
        test_priority;
`else
        test_round_robin;
        test_credit_zero_dequeue;
        test_grant_and_dequeue;
        test_flush;
        test_reset_mid;
        test_back_to_back;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_enqueue_arbiter.md
Name: fifo_enqueue_arbiter

Overview:
- Shares one sync FIFO write port among NUM_REQUESTERS producers using round-robin arbitration.
- Tracks FIFO occupancy with an internal credit counter, so a grant never overflows the FIFO.
- Registers the winning entry and drives it to the FIFO enqueue port one cycle later.
- Sits directly in front of the FIFO's enqueue_en/value_i and observes the FIFO's dequeue_en/flush_en.

Parameters:
- NUM_REQUESTERS, 4, number of producers; 2..16.
- WIDTH, 64, data width; must match the downstream FIFO.
- FIFO_SIZE, 4, downstream FIFO depth; power of two, >= 4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush_en  in  1  synchronous flush; also wired to the FIFO flush.
- request  in  NUM_REQUESTERS  per-requester enqueue request.
- request_data  in  NUM_REQUESTERS x WIDTH  per-requester payload (unpacked array).
- grant_oh  out  NUM_REQUESTERS  one-hot grant; combinational, same cycle as request.
- fifo_enqueue_en  out  1  registered enqueue to the FIFO.
- fifo_value  out  WIDTH  registered payload to the FIFO.
- fifo_dequeue_en  in  1  copy of the FIFO's dequeue_en.
- credits  out  $clog2(FIFO_SIZE)+1  free FIFO slots not yet reserved.

Behaviour:
- Reset (async, reset_n low):
  - credits = FIFO_SIZE.
  - fifo_enqueue_en = 0; fifo_value = 0.
  - Round-robin pointer last_grant = NUM_REQUESTERS-1, so requester 0 has highest priority first.
  - grant_oh = 0 while reset is asserted.
- Grant eligibility:
  - can_grant = credits != 0 && !flush_en.
  - If can_grant and request is nonzero, exactly one bit of grant_oh is set.
  - The winner is the first requester with request set, searching upward from last_grant+1 mod NUM_REQUESTERS.
  - Otherwise grant_oh = 0.
- Handshake: a requester's entry is consumed in the cycle its request and grant_oh bit are both high. The requester may change data or drop request on the next cycle. Request must not depend combinationally on grant_oh.
- On grant:
  - Next edge: last_grant = winner index, fifo_enqueue_en = 1, fifo_value = request_data[winner].
  - Without a grant: fifo_enqueue_en = 0 and fifo_value holds its value.
  - Latency: request to FIFO enqueue is exactly 1 cycle. Throughput is 1 entry per cycle while credits remain.
- Credit arithmetic (width $clog2(FIFO_SIZE)+1):
  - Grant only: credits - 1.
  - fifo_dequeue_en only: credits + 1.
  - Both in the same cycle: unchanged.
  - Credits are reserved at grant, so the registered enqueue in flight is already accounted for.
  - Assertions: credits never exceeds FIFO_SIZE; dequeue never occurs with credits == FIFO_SIZE.
- Flush (flush_en high at the edge):
  - credits = FIFO_SIZE; fifo_enqueue_en = 0, dropping any in-flight entry (the FIFO flush wins anyway).
  - last_grant is unchanged; grant_oh = 0 in the flush cycle.
  - fifo_dequeue_en is ignored in the flush cycle.
- Boundaries:
  - credits == 0 gives no grant, even if a dequeue occurs that cycle; the freed credit is usable the next cycle.
  - Pointer wraps from NUM_REQUESTERS-1 to 0.
  - A single persistent requester is granted every cycle.
- Reset mid-operation: all state returns to reset values immediately. An in-flight enqueue is dropped; the FIFO is reset by the same reset tree.

Optional Feature:
- Macro FIFO_ARB_PRIORITY_EN.
- Defined: requester 0 is a strict high-priority lane. If request[0] and can_grant, requester 0 wins regardless of the pointer, and last_grant is not updated by lane-0 wins. Lanes 1..N-1 round-robin among themselves when lane 0 is idle.
- Undefined: pure round-robin across all lanes.

Decomposition:
- Add to defines.sv:
  - localparam-style constant FIFO_ARB_MAX_REQUESTERS = 16.
  - typedef fifo_arb_credit_t, sized for the maximum FIFO depth.
- Sub-module rr_arbiter (parameter NUM_REQUESTERS):
  - Inputs: request vector, update_lru strobe.
  - Outputs: grant_oh, holding last_grant internally.
  - Reusable by other arbiters in the core.
- Credit counter and output register stay in fifo_enqueue_arbiter.

Test Plan:
- Requests 4'b1111 held continuously, FIFO_SIZE=4, no dequeue -> grants 0,1,2,3 on consecutive cycles. fifo_enqueue_en is high on cycles 2-5. credits goes 3,2,1,0, then grant_oh = 0.
- credits 0 with request 4'b0100, pulse fifo_dequeue_en -> no grant that cycle. Grant to requester 2 the next cycle, credits stays at 0 after that grant.
- Grant and fifo_dequeue_en in the same cycle at credits=2 -> credits stays 2. fifo_value equals the granted data one cycle later.
- flush_en while an entry is in flight and credits=1 -> fifo_enqueue_en = 0 next cycle, credits = 4, last_grant preserved. Next grant proceeds from the preserved pointer.
- Drop reset_n while requests 4'b1010 are active -> grant_oh = 0 immediately, credits = 4. After release, the first grant goes to requester 1.
- FIFO_ARB_PRIORITY_EN defined, request 4'b1011 held -> requester 0 granted every cycle until credits run out. With request 4'b1010, grants alternate 1,3,1,3.
